// File: rtl/alu_muldiv.sv
// Iterative RISC-V M-extension multiply/divide unit.
// One shift-add or restoring step per cycle; fixed latency of BUS_WIDTH+1.
module alu_muldiv #(
   parameter int BUS_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [2:0]           md_op,
   input  logic [BUS_WIDTH-1:0] op1,
   input  logic [BUS_WIDTH-1:0] op2,
   input  logic                 flush,
   output logic [BUS_WIDTH-1:0] result,
   output logic                 result_valid,
   output logic                 zero
);

   localparam int W  = BUS_WIDTH;
   localparam int CW = $clog2(W) + 1;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W-1:0]     opnd_q, opnd_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic             neg1_q, neg1_d;
   logic             neg2_q, neg2_d;
   logic [W-1:0]     res_q, res_d;

   logic             sgn1, sgn2, n1, n2;
   logic [W-1:0]     mag1, mag2;
   logic [W:0]       msum;
   logic [W:0]       rsh;
   logic [W+1:0]     diff;
   logic [2*W-1:0]   mstep, dstep;
   logic [2*W-1:0]   prod_fix;
   logic [W-1:0]     quo_fix, rem_fix;

   // Operand signedness by funct3; MUL low word is sign-agnostic
   assign sgn1 = (md_op == 3'b001) || (md_op == 3'b010) ||
                 (md_op == 3'b100) || (md_op == 3'b110);
   assign sgn2 = (md_op == 3'b001) || (md_op == 3'b100) ||
                 (md_op == 3'b110);
   assign n1   = sgn1 & op1[W-1];
   assign n2   = sgn2 & op2[W-1];
   assign mag1 = n1 ? (W'(0) - op1) : op1;
   assign mag2 = n2 ? (W'(0) - op2) : op2;

   assign msum  = {1'b0, acc_q[2*W-1:W]} +
                  {1'b0, (acc_q[0] ? opnd_q : W'(0))};
   assign mstep = {msum, acc_q[W-1:1]};

   // Extra headroom bit keeps divide-by-zero on the "subtract" path
   assign rsh   = {acc_q[2*W-1:W], acc_q[W-1]};
   assign diff  = {1'b0, rsh} - {2'b00, opnd_q};
   assign dstep = diff[W+1] ?
                  {rsh[W-1:0], acc_q[W-2:0], 1'b0} :
                  {diff[W-1:0], acc_q[W-2:0], 1'b1};

   assign prod_fix = (neg1_q ^ neg2_q) ? ((2*W)'(0) - acc_q) : acc_q;
   assign quo_fix  = ((neg1_q ^ neg2_q) && (opnd_q != W'(0))) ?
                     (W'(0) - acc_q[W-1:0]) : acc_q[W-1:0];
   assign rem_fix  = neg1_q ? (W'(0) - acc_q[2*W-1:W]) :
                     acc_q[2*W-1:W];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      neg1_d  = neg1_q;
      neg2_d  = neg2_q;
      res_d   = res_q;
      unique case (state_q)
         IDLE: begin
            if (op_valid) begin
               state_d = CALC;
               op_d    = md_op;
               cnt_d   = '0;
               neg1_d  = n1;
               neg2_d  = n2;
               opnd_d  = md_op[2] ? mag2 : mag1;
               acc_d   = md_op[2] ? {W'(0), mag1} : {W'(0), mag2};
            end
         end
         CALC: begin
            acc_d = op_q[2] ? dstep : mstep;
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            state_d = DONE;
            unique case (1'b1)
               !op_q[2] && (op_q[1:0] == 2'b00): res_d = prod_fix[W-1:0];
               !op_q[2] && (op_q[1:0] != 2'b00): res_d = prod_fix[2*W-1:W];
               op_q[2] && !op_q[1]:              res_d = quo_fix;
               default:                          res_d = rem_fix;
            endcase
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (flush) begin
         state_d = IDLE;
         res_d   = res_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         op_q    <= '0;
         cnt_q   <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         neg1_q  <= 1'b0;
         neg2_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         neg1_q  <= neg1_d;
         neg2_q  <= neg2_d;
         res_q   <= res_d;
      end
   end

   assign op_ready     = (state_q == IDLE);
   assign result_valid = (state_q == DONE);
   assign result       = res_q;
   assign zero         = (res_q == W'(0));

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv at BUS_WIDTH 32 and 8.
// Expected values are hand-computed constants.
module tb_alu_muldiv;

   logic        clk;
   logic        rst_n;
   logic        op_valid, op_ready, flush;
   logic [2:0]  md_op;
   logic [31:0] op1, op2, result;
   logic        result_valid, zero;

   logic        op_valid8, op_ready8, flush8;
   logic [2:0]  md_op8;
   logic [7:0]  op1_8, op2_8, result8;
   logic        result_valid8, zero8;

   int n_chk;
   int n_fail;

   alu_muldiv #(.BUS_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid), .op_ready(op_ready),
      .md_op(md_op), .op1(op1), .op2(op2),
      .flush(flush), .result(result),
      .result_valid(result_valid), .zero(zero)
   );

   alu_muldiv #(.BUS_WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .op_valid(op_valid8), .op_ready(op_ready8),
      .md_op(md_op8), .op1(op1_8), .op2(op2_8),
      .flush(flush8), .result(result8),
      .result_valid(result_valid8), .zero(zero8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic wait_ready();
      int k;
      k = 0;
      @(negedge clk);
      while (!op_ready && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!op_ready) check("ready_timeout", 0, 1);
   endtask

   task automatic run32(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input string tag);
      int lat;
      wait_ready();
      op_valid = 1'b1;
      md_op    = op;
      op1      = a;
      op2      = b;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      op1      = $urandom;
      op2      = $urandom;
      md_op    = 3'($urandom);
      lat = 0;
      while (!result_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd33);
      check(tag, 64'(result), 64'(exp));
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [7:0] exp,
                       input string tag);
      int lat;
      int k;
      k = 0;
      @(negedge clk);
      while (!op_ready8 && k < 100) begin
         @(negedge clk);
         k++;
      end
      op_valid8 = 1'b1;
      md_op8    = op;
      op1_8     = a;
      op2_8     = b;
      @(posedge clk);
      #1;
      op_valid8 = 1'b0;
      op1_8     = 8'($urandom);
      op2_8     = 8'($urandom);
      lat = 0;
      while (!result_valid8 && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd9);
      check(tag, 64'(result8), 64'(exp));
   endtask

   task automatic no_valid_for(input int cycles, input string tag);
      int seen;
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (result_valid) seen++;
      end
      check(tag, 64'(seen), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n_acc;
      int last_acc;
      logic [31:0] exp_q;
      n_chk     = 0;
      n_fail    = 0;
      rst_n     = 1'b0;
      op_valid  = 1'b0;
      flush     = 1'b0;
      md_op     = 3'b000;
      op1       = '0;
      op2       = '0;
      op_valid8 = 1'b0;
      flush8    = 1'b0;
      md_op8    = 3'b000;
      op1_8     = '0;
      op2_8     = '0;
      #12;
      check("rst_result", 64'(result), 64'd0);
      check("rst_zero", 64'(zero), 64'd1);
      check("rst_ready", 64'(op_ready), 64'd1);
      check("rst_valid", 64'(result_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run32(3'b000, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul");
      check("zero_nz", 64'(zero), 64'd0);

      // Reset mid-CALC
      wait_ready();
      op_valid = 1'b1;
      md_op    = 3'b000;
      op1      = 32'd5;
      op2      = 32'd5;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      repeat (5) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst_result", 64'(result), 64'd0);
      check("arst_zero", 64'(zero), 64'd1);
      check("arst_ready", 64'(op_ready), 64'd1);
      check("arst_valid", 64'(result_valid), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      no_valid_for(40, "arst_stale");
      check("arst_hold", 64'(result), 64'd0);

      run32(3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh");
      run32(3'b011, 32'h80000000, 32'h80000000, 32'h40000000, "mulhu");
      run32(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
      run32(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_ff");
      run32(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, "div");
      run32(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, "rem");
      run32(3'b101, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, "divu");

      // Flush at CALC step 10
      wait_ready();
      op_valid = 1'b1;
      md_op    = 3'b101;
      op1      = 32'd100;
      op2      = 32'd7;
      @(posedge clk);
      #1;
      op_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("flush_ready", 64'(op_ready), 64'd1);
      no_valid_for(40, "flush_novalid");
      check("flush_hold", 64'(result), 64'h7FFFFFFC);

      // flush and op_valid together in IDLE
      @(negedge clk);
      flush    = 1'b1;
      op_valid = 1'b1;
      md_op    = 3'b000;
      op1      = 32'd3;
      op2      = 32'd3;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      op_valid = 1'b0;
      check("flush_noacc", 64'(op_ready), 64'd1);
      no_valid_for(40, "flush_noacc_valid");

      run32(3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, "divu_z");
      run32(3'b111, 32'd5, 32'd0, 32'd5, "remu_z");
      run32(3'b100, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, "div_z");
      run32(3'b110, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, "rem_z");
      run32(3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf");
      run32(3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, "rem_ovf");
      check("rem_ovf_zero", 64'(zero), 64'd1);

      // Held op_valid with operands changing every cycle
      wait_ready();
      n_acc    = 0;
      last_acc = 0;
      exp_q    = '0;
      md_op    = 3'b000;
      op_valid = 1'b1;
      for (int i = 0; i < 110; i++) begin
         if (i > 0) @(negedge clk);
         op1 = 32'(100 + i);
         op2 = 32'd3;
         if (result_valid) check("thr_result", 64'(result), 64'(exp_q));
         if (op_ready) begin
            if (n_acc > 0) check("thr_ii", 64'(i - last_acc), 64'd35);
            last_acc = i;
            exp_q    = 32'((100 + i) * 3);
            n_acc++;
         end
      end
      op_valid = 1'b0;
      check("thr_count", 64'(n_acc), 64'd4);

      run8(3'b000, 8'h07, 8'hFD, 8'hEB, "mul8");
      run8(3'b001, 8'h80, 8'h80, 8'h40, "mulh8");
      run8(3'b011, 8'hFF, 8'hFF, 8'hFE, "mulhu8");
      run8(3'b010, 8'hFF, 8'hFF, 8'hFF, "mulhsu8");

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
